// File: rtl/apx_add_pkg.sv
// rtl/apx_add_pkg.sv - shared FSM state, segment geometry and legality helpers for the segment-gated adder
package apx_add_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_APPLY
  } state_t;

  function automatic int num_segs(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic int lvl_width(input int nsegs);
    return $clog2(nsegs + 1);
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int seg);
    return (seg > 0) && (width % seg == 0);
  endfunction

endpackage

// File: rtl/acc_int_add.sv
// rtl/acc_int_add.sv - plain combinational integer adder, width set by parameter
module acc_int_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/config_int_add_seg_gate.sv
// rtl/config_int_add_seg_gate.sv - 2-stage adder with run-time low-segment operand hold via drain/apply handshake
// Optional feature macro CFG_ZERO_ON_GATE_EN: clear newly gated operand segments when a level is applied.
module config_int_add_seg_gate
  import apx_add_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int SEG_WIDTH          = 8,
  parameter int RESET_LVL          = 0,
  localparam int NUM_SEGS          = num_segs(DATA_PATH_BITWIDTH, SEG_WIDTH),
  localparam int LVL_W             = lvl_width(NUM_SEGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          c_cout,
  input  logic                          cfg_req,
  input  logic [LVL_W-1:0]              cfg_lvl,
  output logic                          cfg_ack,
  output logic [LVL_W-1:0]              cur_lvl
);

  if (!seg_cfg_ok(DATA_PATH_BITWIDTH, SEG_WIDTH)) begin : g_bad_seg
    $error("SEG_WIDTH must divide DATA_PATH_BITWIDTH");
  end
  if (RESET_LVL < 0 || RESET_LVL > NUM_SEGS) begin : g_bad_lvl
    $error("RESET_LVL out of range");
  end

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [LVL_W-1:0]              r_cur_lvl;
  logic [LVL_W-1:0]              r_pend_lvl;
  logic [LVL_W-1:0]              w_req_lvl;
  logic [DATA_PATH_BITWIDTH-1:0] r_a;
  logic [DATA_PATH_BITWIDTH-1:0] r_b;
  logic                          r_v1;
  logic [DATA_PATH_BITWIDTH-1:0] r_c;
  logic                          r_cout;
  logic                          r_v2;
  logic [DATA_PATH_BITWIDTH:0]   w_sum;
  logic                          w_adv1;
  logic                          w_adv2;
  logic                          w_in_ready;
  logic                          w_cfg_ack;
  logic                          w_accept;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign w_accept = in_valid && w_in_ready;
  assign w_req_lvl = (cfg_lvl > LVL_W'(NUM_SEGS)) ? LVL_W'(NUM_SEGS) : cfg_lvl;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_cfg_ack   = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_in_ready = w_adv1;
        if (cfg_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_v1 && !r_v2) w_state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        w_cfg_ack   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_cur_lvl  <= LVL_W'(RESET_LVL);
      r_pend_lvl <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN && cfg_req) r_pend_lvl <= w_req_lvl;
      if (r_state == ST_APPLY) r_cur_lvl <= r_pend_lvl;
    end
  end

  // Thermometer decode of cur_lvl: only segments at or above the level load on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SEGS; k++) begin
        if (w_accept && (LVL_W'(k) >= r_cur_lvl)) begin
          r_a[k*SEG_WIDTH +: SEG_WIDTH] <= a[k*SEG_WIDTH +: SEG_WIDTH];
          r_b[k*SEG_WIDTH +: SEG_WIDTH] <= b[k*SEG_WIDTH +: SEG_WIDTH];
        end
`ifdef CFG_ZERO_ON_GATE_EN
        else if (r_state == ST_APPLY && (LVL_W'(k) < r_pend_lvl)) begin
          r_a[k*SEG_WIDTH +: SEG_WIDTH] <= '0;
          r_b[k*SEG_WIDTH +: SEG_WIDTH] <= '0;
        end
`endif
      end
      if (w_adv1) r_v1 <= w_accept;
    end
  end

  acc_int_add #(
    .WIDTH(DATA_PATH_BITWIDTH + 1)
  ) u_add (
    .i_a  ({1'b0, r_a}),
    .i_b  ({1'b0, r_b}),
    .o_sum(w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c    <= '0;
      r_cout <= 1'b0;
      r_v2   <= 1'b0;
    end else if (w_adv2) begin
      {r_cout, r_c} <= w_sum;
      r_v2          <= r_v1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v2;
  assign c         = r_c;
  assign c_cout    = r_cout;
  assign cfg_ack   = w_cfg_ack;
  assign cur_lvl   = r_cur_lvl;

endmodule

// File: tb/tb_config_int_add_seg_gate.sv
// tb/tb_config_int_add_seg_gate.sv - scoreboard bench for the segment-gated reconfigurable adder
module tb_config_int_add_seg_gate;

  localparam int W   = 32;
  localparam int SEG = 8;
  localparam int NS  = 4;
  localparam int LW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c;
  logic          c_cout;
  logic          cfg_req;
  logic [LW-1:0] cfg_lvl;
  logic          cfg_ack;
  logic [LW-1:0] cur_lvl;

  config_int_add_seg_gate #(
    .DATA_PATH_BITWIDTH(W),
    .SEG_WIDTH(SEG),
    .RESET_LVL(0)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .c_cout(c_cout),
    .cfg_req(cfg_req), .cfg_lvl(cfg_lvl), .cfg_ack(cfg_ack), .cur_lvl(cur_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] sum;
    int         stamp;
    bit         chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] m_a, m_b;
  int          m_lvl = 0;
  int          m_pend = 0;
  int          cyc = 0;
  int          n_acc = 0, n_out = 0, n_ack = 0;
  bit          lat_mode = 1'b0;
  logic [W:0]  last_out = '0;
  logic [W-1:0] da[3], db[3];
  int          bp_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model of the gated operand registers plus the result scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      m_a   = '0;
      m_b   = '0;
      m_lvl = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        last_out = {c_cout, c};
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sum", {31'd0, c_cout, c}, {31'd0, e.sum});
          if (e.chk_lat) check("latency", 64'(cyc - e.stamp), 64'd2);
        end
      end
      if (cfg_ack) begin
        n_ack++;
`ifdef CFG_ZERO_ON_GATE_EN
        for (int k = 0; k < m_pend; k++) begin
          m_a[k*SEG +: SEG] = '0;
          m_b[k*SEG +: SEG] = '0;
        end
`endif
        m_lvl = m_pend;
      end
      if (in_valid && in_ready) begin
        n_acc++;
        for (int k = 0; k < NS; k++) begin
          if (k >= m_lvl) begin
            m_a[k*SEG +: SEG] = a[k*SEG +: SEG];
            m_b[k*SEG +: SEG] = b[k*SEG +: SEG];
          end
        end
        e.sum     = {1'b0, m_a} + {1'b0, m_b};
        e.stamp   = cyc;
        e.chk_lat = lat_mode;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 64'(ok), 64'd1);
    tick();
  endtask

  task automatic wait_ack(output bit seen, output int ready_hi);
    seen     = 1'b0;
    ready_hi = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      if (cfg_ack) begin
        seen = 1'b1;
        check("ready_in_apply", 64'(in_ready), 64'd0);
        break;
      end
      if (in_ready) ready_hi++;
      @(posedge clk);
      #1;
    end
    tick();
  endtask

  task automatic offer_beats(input int cycles);
    for (int cy = 0; cy < cycles; cy++) begin
      if (bp_i < 3) begin
        a = da[bp_i];
        b = db[bp_i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) bp_i++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int ready_hi, acc0, out0, ack0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; cfg_req = 1'b0; cfg_lvl = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cur_lvl", 64'(cur_lvl), 64'd0);
    check("rst_cfg_ack", 64'(cfg_ack), 64'd0);
    check("rst_c", {31'd0, c_cout, c}, 64'd0);
    tick();

    lat_mode = 1'b1;
    a = 32'h0000_0005; b = 32'h0000_0003; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
    check("t1_c", 64'(last_out), 64'h0_0000_0008);

    a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
    check("t2_c_cout", 64'(last_out), 64'h1_0000_0000);
    lat_mode = 1'b0;

    a = 32'h1111_2222; b = 32'h0101_0101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
    check("t3_first", 64'(last_out), 64'h0_1212_2323);
    m_pend = 2; cfg_req = 1'b1; cfg_lvl = 3'd2;
    tick();
    cfg_req = 1'b0;
    for (int i = 0; i < 20 && !cfg_ack; i++) @(negedge clk);
    check("t3_ack_seen", 64'(cfg_ack), 64'd1);
    tick();
    check("t3_cur_lvl", 64'(cur_lvl), 64'd2);
    a = 32'h2222_FFFF; b = 32'h1111_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
`ifdef CFG_ZERO_ON_GATE_EN
    check("t3_gated", 64'(last_out), 64'h0_3333_0000);
`else
    check("t3_gated", 64'(last_out), 64'h0_3333_2323);
`endif

    for (int i = 0; i < 3; i++) begin
      da[i] = $urandom;
      db[i] = $urandom;
    end
    acc0 = n_acc; out0 = n_out; bp_i = 0;
    out_ready = 1'b0;
    offer_beats(6);
    check("bp_accepted", 64'(n_acc - acc0), 64'd2);
    in_valid = 1'b1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    offer_beats(10);
    wait_idle();
    check("bp_outputs", 64'(n_out - out0), 64'd3);

    ack0 = n_ack;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      tick();
    end
    m_pend = 4; cfg_req = 1'b1; cfg_lvl = 3'd7;
    a = $urandom; b = $urandom;
    tick();
    cfg_req = 1'b0;
    wait_ack(seen, ready_hi);
    check("cfg7_ack_seen", 64'(seen), 64'd1);
    check("cfg7_ready_low", 64'(ready_hi), 64'd0);
    check("cfg7_cur_lvl", 64'(cur_lvl), 64'd4);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_idle();
    check("cfg7_ack_count", 64'(n_ack - ack0), 64'd1);

    ack0 = n_ack;
    out_ready = 1'b0;
    a = $urandom; b = $urandom; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    m_pend = 1; cfg_req = 1'b1; cfg_lvl = 3'd1;
    tick();
    cfg_req = 1'b0;
    tick();
    tick();
    check("drain_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_drain_out_valid", 64'(out_valid), 64'd0);
    check("rst_drain_cur_lvl", 64'(cur_lvl), 64'd0);
    check("rst_drain_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    repeat (5) tick();
    check("rst_drain_no_ack", 64'(n_ack - ack0), 64'd0);

    a = 32'h0F0F_0F0F; b = 32'h1010_1010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle();
    check("post_rst_sum", 64'(last_out), 64'h0_1F1F_1F1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/config_int_add_seg_gate.md
# config_int_add_seg_gate

Pipelined approximate integer adder that splits the operand datapath into equal segments. It holds the low `lvl` segments of each operand register when a beat is accepted, so they keep their previous contents and stop toggling. Unlike the fixed-split clock-gated adder, the gated depth is reconfigurable at run time through a drain-and-apply handshake, and both input and output carry valid/ready flow control. It sits between operand producers and accumulator/consumer logic in the approximate-arithmetic datapath.

## Interface
- `DATA_PATH_BITWIDTH`, 32, operand/result width
- `SEG_WIDTH`, 8, bits per gating segment; must divide `DATA_PATH_BITWIDTH`
- `RESET_LVL`, 0, gated-segment count after reset, 0..NUM_SEGS
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block accepts operand beat
- `a` in DATA_PATH_BITWIDTH: operand A
- `b` in DATA_PATH_BITWIDTH: operand B
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `c` out DATA_PATH_BITWIDTH: sum, modulo 2^DATA_PATH_BITWIDTH
- `c_cout` out 1: carry out of the MSB
- `cfg_req` in 1: request a gating-level change
- `cfg_lvl` in clog2(NUM_SEGS+1): requested number of gated low segments
- `cfg_ack` out 1: one-cycle pulse when the new level takes effect
- `cur_lvl` out clog2(NUM_SEGS+1): active gating level

## Operation
- NUM_SEGS = DATA_PATH_BITWIDTH / SEG_WIDTH. Segment k spans bits [k·SEG_WIDTH +: SEG_WIDTH].
- Stage 1 registers are `reg_a`, `reg_b`, `v1`. Stage 2 registers are `reg_c`, `c_cout`, `v2`.
- `adv2 = !v2 | out_ready`; `adv1 = !v1 | adv2`.
- Accept occurs when `in_valid & in_ready`.
- On accept, segment k of `reg_a`/`reg_b` loads from `a`/`b` only if k ≥ `cur_lvl`. Segments with k < `cur_lvl` hold their value.
- `v1` loads `accept` when `adv1`.
- When `adv2`: `{c_cout, reg_c}` ← `reg_a + reg_b` (DATA_PATH_BITWIDTH+1-bit sum) and `v2` ← `v1`.
- `out_valid = v2`.
- The full-width sum is always computed, with carries propagating through the held segments.
- FSM states are RUN, DRAIN, APPLY.
  - RUN: `in_ready = adv1`. If `cfg_req` is high, capture `min(cfg_lvl, NUM_SEGS)` into `pend_lvl` and go to DRAIN. A beat accepted in the same cycle is kept.
  - DRAIN: `in_ready = 0`. Go to APPLY once `v1 == 0 && v2 == 0`.
  - APPLY: `in_ready = 0`; `cur_lvl` ← `pend_lvl`; `cfg_ack = 1`; go to RUN.
- `cfg_req` is ignored outside RUN.
- Reset values: all registers 0, `cur_lvl` = RESET_LVL, state RUN, `in_ready` = 1 in the cycle after reset, `cfg_ack` = 0.
- Reset mid-DRAIN or mid-APPLY discards the pending request and in-flight beats; no `cfg_ack` is issued.
- `cur_lvl = NUM_SEGS` is legal. Every accept then holds all operand bits and the output repeats the held sum.

## Timing
- Latency is 2 cycles from accept to `out_valid` with no backpressure. Throughput is 1 beat/cycle.
- Under backpressure the pipeline holds 2 beats. `in_ready` drops in the cycle when both stages are full and `out_ready` = 0.
- Beats are never dropped or reordered.
- Reconfiguration latency is the drain time plus 1 APPLY cycle. The first beat using the new level is accepted in the cycle after `cfg_ack`.

## Configuration
- `CFG_ZERO_ON_GATE_EN` defined: in APPLY, gated segments of `reg_a` and `reg_b` (k < `pend_lvl`) are cleared to 0. The low part of the result is then deterministic truncation.
- `CFG_ZERO_ON_GATE_EN` undefined: gated segments keep their stale operand values (pure hold, lowest toggle).

## Structure
- Package `apx_add_pkg` holds:
  - the FSM state enum
  - NUM_SEGS and level-width derivation functions
  - the parameter legality check (SEG_WIDTH divides DATA_PATH_BITWIDTH)
- Per-segment load enables come from a thermometer decode of `cur_lvl` and are written inline.
- Sub-module: the existing `acc_int_add` instantiated for the full-width sum. It is widened by one bit (zero-extended operands) to produce `c_cout`.

## Test plan
Defaults: W=32, SEG=8.
- Reset, lvl 0; a=0x00000005, b=0x00000003 accepted at cycle t → `c`=0x00000008, `c_cout`=0, `out_valid` at t+2.
- a=0xFFFFFFFF, b=0x00000001 → `c`=0x00000000, `c_cout`=1.
- a=0x11112222, b=0x01010101 at lvl 0, then set lvl 2, then a=0x2222FFFF, b=0x1111FFFF.
  - Macro undefined → `c`=0x33332323.
  - Macro defined → `c`=0x33330000.
- `out_ready`=0 with 3 beats offered → exactly 2 accepted and `in_ready`=0. Release → all 3 results emerge in order, no gaps lost.
- `cfg_req` with `cfg_lvl`=7 during continuous traffic → `in_ready` low until pipe empty, one `cfg_ack` pulse, then `cur_lvl`=4.
- `rst` asserted during DRAIN → next cycle `out_valid`=0, `cur_lvl`=RESET_LVL, no `cfg_ack` ever pulsed.
